// File: rtl/pipelined_parallel_adder.sv
// WIDTH-bit adder with the carry chain split into STAGES registered segments, valid/ready streaming.
// Define PPA_OVERFLOW_EN to add the registered signed-overflow output Ovf.
module pipelined_parallel_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef PPA_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_parallel_adder: STAGES must be 1..WIDTH and divide WIDTH");
  end

  // Valid/ready: a transfer happens on a rising edge where valid && ready are both high.
  // The whole pipeline moves as one; it stalls only when a result is waiting downstream.
  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = rst || w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits still to be added when entering this stage (current segment at bit 0).
    localparam int REM = WIDTH - k * SEG;

    logic [REM-1:0]         w_a;
    logic [REM-1:0]         w_b;
    logic                   w_c;
    logic                   w_v;
    logic [SEG:0]           w_add;
    logic [(k+1)*SEG-1:0]   w_sum_next;
    logic                   r_valid;
    logic                   r_carry;
    logic [(k+1)*SEG-1:0]   r_sum;

    if (k == 0) begin : g_in
      assign w_a        = A;
      assign w_b        = B;
      assign w_c        = Cin;
      assign w_v        = in_valid;
      assign w_sum_next = w_add[SEG-1:0];
    end else begin : g_in
      assign w_a        = g_stg[k-1].g_skew.r_a;
      assign w_b        = g_stg[k-1].g_skew.r_b;
      assign w_c        = g_stg[k-1].r_carry;
      assign w_v        = g_stg[k-1].r_valid;
      assign w_sum_next = {w_add[SEG-1:0], g_stg[k-1].r_sum};
    end

    assign w_add = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_c};

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (w_adv) begin
        r_valid <= w_v;
        r_carry <= w_add[SEG];
        r_sum   <= w_sum_next;
      end
    end

    // Skew registers carry the not-yet-added operand bits (incl. sign bits) to later stages.
    if (REM > SEG) begin : g_skew
      logic [REM-SEG-1:0] r_a;
      logic [REM-SEG-1:0] r_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[REM-1:SEG];
          r_b <= w_b[REM-1:SEG];
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].r_valid;
  assign Sum       = g_stg[STAGES-1].r_sum;
  assign Cout      = g_stg[STAGES-1].r_carry;

`ifdef PPA_OVERFLOW_EN
  // In the last stage the top bit of each remaining operand segment is the original sign bit.
  logic w_ovf_next;
  logic r_ovf;

  assign w_ovf_next = (g_stg[STAGES-1].w_a[SEG-1] == g_stg[STAGES-1].w_b[SEG-1]) &&
                      (g_stg[STAGES-1].w_add[SEG-1] != g_stg[STAGES-1].w_a[SEG-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_ovf_next;
    end
  end

  assign Ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_parallel_adder.sv
// Bench for pipelined_parallel_adder: main 16/4 instance plus STAGES=1 and STAGES=16 instances.
// Honours PPA_OVERFLOW_EN when the build defines it.
module tb_pipelined_parallel_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;

  logic        c_valid;
  logic [15:0] c_a;
  logic [15:0] c_b;
  logic        c_cin;
  logic        c_oready;
  logic        s1_ready, s1_valid, s1_cout;
  logic [15:0] s1_sum;
  logic        s16_ready, s16_valid, s16_cout;
  logic [15:0] s16_sum;
`ifdef PPA_OVERFLOW_EN
  logic        ovf, s1_ovf, s16_ovf;
`endif

  int tests_run;
  int tests_failed;
  logic [17:0] exp_q[$];

  pipelined_parallel_adder #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .Cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(sum), .Cout(cout)
`ifdef PPA_OVERFLOW_EN
    , .Ovf(ovf)
`endif
  );

  pipelined_parallel_adder #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(s1_ready),
    .A(c_a), .B(c_b), .Cin(c_cin), .out_valid(s1_valid), .out_ready(c_oready),
    .Sum(s1_sum), .Cout(s1_cout)
`ifdef PPA_OVERFLOW_EN
    , .Ovf(s1_ovf)
`endif
  );

  pipelined_parallel_adder #(.WIDTH(16), .STAGES(16)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(s16_ready),
    .A(c_a), .B(c_b), .Cin(c_cin), .out_valid(s16_valid), .out_ready(c_oready),
    .Sum(s16_sum), .Cout(s16_cout)
`ifdef PPA_OVERFLOW_EN
    , .Ovf(s16_ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- model and checking ----------------
  // Returns {ovf, cout, sum} for a 16-bit add.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [31:0] t;
    logic [15:0] s;
    logic        ov;
    t  = 32'(a) + 32'(b) + 32'(c);
    s  = t[15:0];
    ov = (a[15] == b[15]) && (s[15] != a[15]);
    return {ov, t[16], s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: push on accept, compare every valid output cycle, pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious out_valid", 32'(out_valid), 32'd0);
        end else begin
          check("sum/cout", {15'd0, cout, sum}, {15'd0, exp_q[0][16:0]});
`ifdef PPA_OVERFLOW_EN
          check("ovf", 32'(ovf), 32'(exp_q[0][17]));
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      check("in_ready rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (in_valid && in_ready) exp_q.push_back(model(a_in, b_in, cin));
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that accepted the item.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    cin      = c;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // ---------------- directed vectors ----------------
  logic [15:0] tv_a   [8] = '{16'h0001, 16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0F0F, 16'h00FF, 16'hABCD};
  logic [15:0] tv_b   [8] = '{16'h0001, 16'h4321, 16'h8000, 16'h0001, 16'hFFFF, 16'hF0F0, 16'h0001, 16'h1111};
  logic        tv_c   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [16:0] tv_exp [8] = '{17'h00002, 17'h05555, 17'h10000, 17'h08000,
                              17'h1FFFF, 17'h10000, 17'h00100, 17'h0BCDF};

  initial begin
    int lat;
    int lat1;
    int lat16;
    logic [16:0] got;
    logic [16:0] got1;
    logic [16:0] got16;
    int run;
    int seen;

    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    c_valid   = 1'b0;
    c_a       = '0;
    c_b       = '0;
    c_cin     = 1'b0;
    c_oready  = 1'b1;

    // Model pins
    check("model 1234+4321", 32'(model(16'h1234, 16'h4321, 1'b0)), 32'h05555);
    check("model 7FFF+0001", 32'(model(16'h7FFF, 16'h0001, 1'b0)), 32'h28000);
    check("model 8000+FFFF", 32'(model(16'h8000, 16'hFFFF, 1'b0)), 32'h37FFF);
    check("model 0001+0001", 32'(model(16'h0001, 16'h0001, 1'b0)), 32'h00002);
    for (int i = 0; i < 8; i++)
      check("model table", 32'(model(tv_a[i], tv_b[i], tv_c[i]) & 18'h1FFFF), 32'(tv_exp[i]));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_ready in reset", 32'(in_ready), 32'd1);
    check("out_valid in reset", 32'(out_valid), 32'd0);
    check("sum in reset", 32'(sum), 32'd0);
    check("cout in reset", 32'(cout), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", 32'(in_ready), 32'd1);
    check("out_valid after reset", 32'(out_valid), 32'd0);
    check("s1 out_valid after reset", 32'(s1_valid), 32'd0);
    check("s16 out_valid after reset", 32'(s16_valid), 32'd0);
    check("s16 sum after reset", 32'(s16_sum), 32'd0);
    @(posedge clk);
    #1;

    // Carry across all segments, latency 4
    in_valid = 1'b1;
    a_in = 16'hFFFF;
    b_in = 16'h0001;
    cin  = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    got = '0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      if (out_valid) begin
        lat = n;
        got = {cout, sum};
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("latency 4", lat, 4);
    check("FFFF+0001", 32'(got), 32'h10000);
    wait_drain();

    // Streaming 8 back-to-back, expecting 8 consecutive outputs
    fork
      begin
        for (int i = 0; i < 8; i++) send(tv_a[i], tv_b[i], tv_c[i]);
      end
      begin
        run = 0;
        for (int t = 0; t < 40; t++) begin
          @(negedge clk);
          if (out_valid) run++;
          else if (run > 0) break;
        end
        check("stream consecutive", run, 8);
      end
    join
    wait_drain();

    // Backpressure
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0);
    send(16'hFFFE, 16'h0001, 1'b1);
    send(16'h4000, 16'h4000, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall in_ready", 32'(in_ready), 32'd0);
      check("stall held", 32'({cout, sum}), 32'h03333);
      check("stall out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    // Reset mid-flight
    send(16'h5555, 16'h1111, 1'b0);
    send(16'h0000, 16'h0000, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready during reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset sum", 32'(sum), 32'd0);
    check("midreset cout", 32'(cout), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("discarded results", seen, 0);
    @(posedge clk);
    #1;

    // Overflow cases (Ovf checked by the scoreboard when the port exists)
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'hFFFF, 1'b0);
    send(16'h0001, 16'h0001, 1'b0);
    wait_drain();

    // Config sweep: STAGES=1 and STAGES=16
    c_valid = 1'b1;
    c_a   = 16'hAAAA;
    c_b   = 16'h5555;
    c_cin = 1'b1;
    @(negedge clk);
    check("s1 in_ready", 32'(s1_ready), 32'd1);
    check("s16 in_ready", 32'(s16_ready), 32'd1);
    @(posedge clk);
    #1 c_valid = 1'b0;
    lat1  = 0;
    lat16 = 0;
    got1  = '0;
    got16 = '0;
    for (int n = 1; n <= 40 && (lat1 == 0 || lat16 == 0); n++) begin
      if (s1_valid && lat1 == 0) begin
        lat1 = n;
        got1 = {s1_cout, s1_sum};
      end
      if (s16_valid && lat16 == 0) begin
        lat16 = n;
        got16 = {s16_cout, s16_sum};
      end
      @(posedge clk);
      #1;
    end
    check("s1 latency", lat1, 1);
    check("s16 latency", lat16, 16);
    check("s1 AAAA+5555+1", 32'(got1), 32'h10000);
    check("s16 AAAA+5555+1", 32'(got16), 32'h10000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
